average_inverse_filter: RTL and testbench
=========================================

AVERAGE_INVERSE_FILTER -- requirements
Module: average_inverse_filter

Interface
REQ-001 SHALL: parameter DATA_WIDTH, default 8, sample width in bits (signed two's complement), minimum 4.
REQ-002 SHALL: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL: i_ce  input  1  input sample strobe; data_in valid when high.
REQ-005 SHALL: i_sync  input  1  resynchronise; discards reconstruction history.
REQ-006 SHALL: i_clr_sat  input  1  clears sticky saturation flag.
REQ-007 SHALL: data_in  input  DATA_WIDTH  signed 2-tap-averaged sample y[n].
REQ-008 SHALL: data_out  output  DATA_WIDTH  signed reconstructed sample x[n], registered.
REQ-009 SHALL: o_ce  output  1  one-cycle strobe, data_out updated.
REQ-010 SHALL: o_sat  output  1  sticky flag, a reconstruction exceeded signed range.

Function
REQ-011 SHALL: implement inverse of 2-tap average: x[n] = 2*y[n] - x[n-1]; reconstruction is lossy where the forward filter truncated.
REQ-012 SHALL: two-state FSM PRIME (no history) and RUN (history valid); reset state PRIME.
REQ-013 SHALL: in PRIME, i_ce high -> data_out = data_in, history = data_in, next state RUN.
REQ-014 SHALL: in RUN, i_ce high -> data_out = fit(2*data_in - history), history = that same output value, stay RUN.
REQ-015 SHALL: compute 2*data_in - history in DATA_WIDTH+2 bits signed, sign-extended, no intermediate overflow.
REQ-016 SHALL: latency exactly one clock: o_ce high in the cycle after each accepted i_ce, low otherwise; back-to-back i_ce gives o_ce every cycle.
REQ-017 SHALL: data_out and history hold their values while i_ce low.
REQ-018 SHALL: i_sync high -> next state PRIME; if i_ce high same cycle, that sample is processed per REQ-013 (treated as first sample).
REQ-019 SHALL: i_sync does not alter data_out, o_ce pulse generation, or o_sat.
REQ-020 SHALL: o_sat set when a RUN-state result is outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; cleared by i_clr_sat; set wins over simultaneous clear.
REQ-021 SHALL: no backpressure; every i_ce sample is accepted.

Reset
REQ-022 SHALL: on reset assertion, immediately: data_out = 0, o_ce = 0, o_sat = 0, history = 0, state PRIME.
REQ-023 SHALL: reset mid-stream discards history; first i_ce after deassertion handled per REQ-013.
REQ-024 SHALL: i_ce asserted during reset is ignored and produces no o_ce.

Configuration
REQ-025 SHALL: macro AVG_INV_SATURATE_EN defined -> fit() saturates to signed DATA_WIDTH range and o_sat operates per REQ-020.
REQ-026 SHALL: macro AVG_INV_SATURATE_EN undefined -> fit() keeps low DATA_WIDTH bits (two's-complement wrap), o_sat tied to 0, i_clr_sat unused.

Verification (DATA_WIDTH=8)
REQ-027 SHALL: reset pulse -> data_out=0, o_ce=0, o_sat=0; first sample y=10 -> x=10 one cycle later with o_ce.
REQ-028 SHALL: y stream 10,-5,5,-5 back-to-back -> x stream 10,-20,30,-40, o_ce high four consecutive cycles.
REQ-029 SHALL: with macro, y=100 then y=-100 -> 100 then -128, o_sat=1 until i_clr_sat; y=-100 then y=100 -> -100 then 127; without macro, y=100 then y=-100 -> 100 then -44, o_sat=0.
REQ-030 SHALL: y=10,-5, then y=7 with i_sync and i_ce in same cycle -> 10,-20,7; next y=4 -> 1.
REQ-031 SHALL: y=10, three idle cycles, y=-5 -> data_out holds 10 while idle, then -20; o_ce single-cycle pulses only.
REQ-032 SHALL: y=10,-5, reset asserted one cycle, then y=3 -> outputs 0 during reset, then 3 (PRIME behaviour).

Source files
------------

// File: rtl/average_inverse_filter_if.sv
// Sample stream bundle for the inverse 2-tap average filter.
// Master drives samples and controls; slave returns reconstructions.
interface average_inverse_filter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                         i_ce;
  logic                         i_sync;
  logic                         i_clr_sat;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic signed [DATA_WIDTH-1:0] data_out;
  logic                         o_ce;
  logic                         o_sat;

  modport master (
    output i_ce, i_sync, i_clr_sat, data_in,
    input  data_out, o_ce, o_sat
  );

  modport slave (
    input  i_ce, i_sync, i_clr_sat, data_in,
    output data_out, o_ce, o_sat
  );
endinterface

// File: rtl/average_inverse_filter.sv
// Inverse of a 2-tap average: x[n] = 2*y[n] - x[n-1].
// Define AVG_INV_SATURATE_EN to saturate results and enable o_sat.
module average_inverse_filter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  average_inverse_filter_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int SW = DATA_WIDTH + 2;

  localparam logic signed [SW-1:0] MAXV =
    {3'b000, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV =
    {3'b111, {(W-1){1'b0}}};

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic signed [W-1:0]  data_q, data_d;
  logic signed [W-1:0]  hist_q, hist_d;
  logic                 oce_q, oce_d;
  logic                 sat_q, sat_d;

  logic signed [SW-1:0] din_x;
  logic signed [SW-1:0] hist_x;
  logic signed [SW-1:0] sum;
  logic                 ovf_hi;
  logic                 ovf_lo;
  logic signed [W-1:0]  fit;
  logic                 eff_run;

  // Widened difference cannot overflow: |2y - h| < 2^(W+1).
  assign din_x  = {{2{bus.data_in[W-1]}}, bus.data_in};
  assign hist_x = {{2{hist_q[W-1]}}, hist_q};
  assign sum    = (din_x <<< 1) - hist_x;
  assign ovf_hi = (sum > MAXV);
  assign ovf_lo = (sum < MINV);

`ifdef AVG_INV_SATURATE_EN
  assign fit = ovf_hi ? MAXV[W-1:0] :
               ovf_lo ? MINV[W-1:0] :
               sum[W-1:0];
`else
  assign fit = sum[W-1:0];
  logic unused_wrap;
  assign unused_wrap = ^{bus.i_clr_sat, ovf_hi, ovf_lo};
`endif

  // A sync request forces this cycle's sample to be a first sample.
  assign eff_run = (state_q == RUN) && !bus.i_sync;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: any accepted sample leaves history valid.
  always_comb begin
    state_d = eff_run ? RUN : PRIME;
    if (bus.i_ce) begin
      state_d = RUN;
    end
  end

  // Output/datapath next values.
  always_comb begin
    data_d = data_q;
    hist_d = hist_q;
    oce_d  = bus.i_ce;
    sat_d  = sat_q;
`ifdef AVG_INV_SATURATE_EN
    if (bus.i_clr_sat) begin
      sat_d = 1'b0;
    end
`else
    sat_d = 1'b0;
`endif
    unique case (1'b1)
      bus.i_ce && !eff_run: begin
        data_d = bus.data_in;
        hist_d = bus.data_in;
      end
      bus.i_ce && eff_run: begin
        data_d = fit;
        hist_d = fit;
`ifdef AVG_INV_SATURATE_EN
        if (ovf_hi || ovf_lo) begin
          sat_d = 1'b1;
        end
`endif
      end
      default: begin
      end
    endcase
  end

  // Output and history registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      hist_q <= '0;
      oce_q  <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      hist_q <= hist_d;
      oce_q  <= oce_d;
      sat_q  <= sat_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.o_ce     = oce_q;
  assign bus.o_sat    = sat_q;
endmodule

// File: tb/tb_average_inverse_filter.sv
// Scoreboard bench for average_inverse_filter (DATA_WIDTH=8).
// Expected values follow AVG_INV_SATURATE_EN when defined.
module tb_average_inverse_filter;
  logic clk;
  logic reset;

  average_inverse_filter_if #(.DATA_WIDTH(8)) bus ();

  average_inverse_filter #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic              sat;
    logic signed [7:0] d;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

`ifdef AVG_INV_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every o_ce pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.o_ce === 1'b1) begin
      if (q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL spurious_oce: got o_ce=1 expected none, data_out=%0d",
                 bus.data_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("data_out", int'(bus.data_out), int'(e.d));
        chk("o_sat", int'(bus.o_sat), int'(e.sat));
      end
    end
  end

  task automatic cyc(input logic ce, input logic sync, input logic clr,
                     input logic signed [7:0] y,
                     input logic signed [7:0] ed, input logic es);
    exp_t e;
    @(posedge clk);
    #1;
    bus.i_ce      = ce;
    bus.i_sync    = sync;
    bus.i_clr_sat = clr;
    bus.data_in   = y;
    if (ce) begin
      e.d   = ed;
      e.sat = es;
      q.push_back(e);
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 8'sd0, 8'sd0, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.i_ce      = 1'b1;
    bus.i_sync    = 1'b0;
    bus.i_clr_sat = 1'b0;
    bus.data_in   = 8'sd55;
    repeat (3) @(negedge clk);
    chk("rst_data_out", int'(bus.data_out), 0);
    chk("rst_o_ce", int'(bus.o_ce), 0);
    chk("rst_o_sat", int'(bus.o_sat), 0);
    bus.i_ce = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;

    // First sample after reset passes through.
    cyc(1, 0, 0, 8'sd10, 8'sd10, 0);
    idle();

    // Back-to-back stream.
    cyc(1, 1, 0, 8'sd10, 8'sd10, 0);
    cyc(1, 0, 0, -8'sd5, -8'sd20, 0);
    cyc(1, 0, 0, 8'sd5, 8'sd30, 0);
    cyc(1, 0, 0, -8'sd5, -8'sd40, 0);
    idle();

    // Overflow low, then sticky flag and clear.
    cyc(1, 1, 0, 8'sd100, 8'sd100, 0);
    cyc(1, 0, 0, -8'sd100, SAT ? 8'h80 : -8'sd44, SAT);
    cyc(1, 1, 0, 8'sd10, 8'sd10, SAT);
    cyc(0, 0, 1, 8'sd0, 8'sd0, 0);
    idle();
    @(negedge clk);
    chk("sat_cleared", int'(bus.o_sat), 0);

    // Overflow high with a simultaneous clear: set wins.
    cyc(1, 1, 0, -8'sd100, -8'sd100, 0);
    cyc(1, 0, 1, 8'sd100, SAT ? 8'sd127 : 8'sd44, SAT);
    cyc(0, 0, 1, 8'sd0, 8'sd0, 0);
    idle();

    // Resync mid-stream.
    cyc(1, 1, 0, 8'sd10, 8'sd10, 0);
    cyc(1, 0, 0, -8'sd5, -8'sd20, 0);
    cyc(1, 1, 0, 8'sd7, 8'sd7, 0);
    cyc(1, 0, 0, 8'sd4, 8'sd1, 0);
    idle();

    // Hold while idle.
    cyc(1, 1, 0, 8'sd10, 8'sd10, 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      @(negedge clk);
      chk("hold_data_out", int'(bus.data_out), 10);
    end
    cyc(1, 0, 0, -8'sd5, -8'sd20, 0);
    idle();

    // Asynchronous reset mid-stream discards history.
    cyc(1, 1, 0, 8'sd10, 8'sd10, 0);
    cyc(1, 0, 0, -8'sd5, -8'sd20, 0);
    idle();
    @(posedge clk);
    #1;
    reset       = 1'b1;
    bus.i_ce    = 1'b1;
    bus.data_in = 8'sd50;
    #1;
    chk("async_rst_data_out", int'(bus.data_out), 0);
    chk("async_rst_o_ce", int'(bus.o_ce), 0);
    chk("async_rst_o_sat", int'(bus.o_sat), 0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    bus.i_ce = 1'b0;
    cyc(1, 0, 0, 8'sd3, 8'sd3, 0);
    cyc(1, 0, 0, 8'sd2, 8'sd1, 0);
    idle();

    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
